// File: rtl/shared_resource_mul.sv
// Iterative 16x16 shift-add multiplier shared between pipeline stages 3 and 4.
// Holds one word in flight, back-pressures stage 3 and forwards flushes to stage 4.
module shared_resource_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_flush,
  output logic             out_stall,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_flush,
  input  logic             in_stall
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [HALF-1:0]  b_r, b_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] out_data_r, out_data_s;
  logic             out_valid_r, out_valid_s;
  logic             out_flush_r;
  logic [WIDTH-1:0] acc_sum_s;

  // Partial product for the current multiplier bit; the final add feeds out_data directly.
  assign acc_sum_s = b_r[0] ? (acc_r + a_r) : acc_r;

  assign out_stall = (state_r != IDLE);
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_flush = out_flush_r;

  // Next-state and datapath decode; flush overrides every state.
  always_comb begin
    state_s     = state_r;
    a_s         = a_r;
    b_s         = b_r;
    acc_s       = acc_r;
    cnt_s       = cnt_r;
    out_data_s  = out_data_r;
    out_valid_s = out_valid_r;
    if (in_flush) begin
      state_s     = IDLE;
      out_valid_s = 1'b0;
      acc_s       = {WIDTH{1'b0}};
      cnt_s       = {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_s     = {{HALF{1'b0}}, in_data[WIDTH-1:HALF]};
            b_s     = in_data[HALF-1:0];
            acc_s   = {WIDTH{1'b0}};
            cnt_s   = {CW{1'b0}};
            state_s = BUSY;
          end else begin
            state_s = IDLE;
          end
        end
        BUSY: begin
          acc_s = acc_sum_s;
          a_s   = a_r << 1;
          b_s   = b_r >> 1;
          cnt_s = cnt_r + 1'b1;
          if (cnt_r == CNT_LAST) begin
            out_data_s  = acc_sum_s;
            out_valid_s = 1'b1;
            state_s     = DONE;
          end else begin
            state_s = BUSY;
          end
        end
        DONE: begin
          // No operand is taken here, even on the handoff edge.
          if (!in_stall) begin
            out_valid_s = 1'b0;
            state_s     = IDLE;
          end else begin
            state_s = DONE;
          end
        end
        default: begin
          state_s     = IDLE;
          out_valid_s = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {HALF{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      out_data_r  <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      out_flush_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      a_r         <= a_s;
      b_r         <= b_s;
      acc_r       <= acc_s;
      cnt_r       <= cnt_s;
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
      out_flush_r <= in_flush;
    end
  end

endmodule

// File: tb/tb_shared_resource_mul.sv
// Self-checking bench for shared_resource_mul: a cycle-level behavioural model
// checked every cycle, plus directed vectors with hand-computed products.
module tb_shared_resource_mul;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_flush = 1'b0;
  logic        in_stall = 1'b0;
  logic        out_stall;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_flush;

  int tests = 0;
  int fails = 0;

  shared_resource_mul #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_flush(in_flush), .out_stall(out_stall), .out_data(out_data),
    .out_valid(out_valid), .out_flush(out_flush), .in_stall(in_stall)
  );

  always #5 clk = ~clk;

  // Behavioural model: a word costs 16 cycles of work, then waits for stage 4.
  int          m_left;
  logic        m_done, m_valid, m_flush;
  logic [31:0] m_data, m_prod;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left <= 0; m_done <= 1'b0; m_valid <= 1'b0; m_flush <= 1'b0;
      m_data <= 32'd0; m_prod <= 32'd0;
    end else begin
      m_flush <= in_flush;
      if (in_flush) begin
        m_left <= 0; m_done <= 1'b0; m_valid <= 1'b0;
      end else if (m_done) begin
        if (!in_stall) begin
          m_done <= 1'b0; m_valid <= 1'b0;
        end
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b0 | 1'b1; m_valid <= 1'b1; m_data <= m_prod;
        end
      end else if (in_valid) begin
        m_prod <= 32'(in_data[31:16] * in_data[15:0]);
        m_left <= 16;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, sampled away from the active edge.
  always @(negedge clk) begin
    check("model_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("model_out_stall", {31'd0, out_stall}, {31'd0, (m_left != 0) || m_done});
    check("model_out_flush", {31'd0, out_flush}, {31'd0, m_flush});
    if (m_valid) check("model_out_data", out_data, m_data);
  end

  task automatic send(input logic [31:0] w);
    @(negedge clk); in_data = w; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (!out_valid && c < 40) begin
      @(negedge clk); c++;
    end
    if (!out_valid) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic quiet(input int n, input string name);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check(name, seen, 32'd0);
  endtask

  task automatic run_word(input logic [31:0] w, input logic [31:0] exp, input string name);
    int c;
    send(w);
    wait_valid(c);
    check({name, "_latency"}, c, 32'd16);
    check(name, out_data, exp);
    @(negedge clk);
    check({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int c;
    logic [31:0] held;
    int stall_cnt;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_stall", {31'd0, out_stall}, 32'd0);
    check("rst_out_flush", {31'd0, out_flush}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    reset = 1'b1;

    // Basic: stall is high for 17 cycles, product after 16.
    send(32'h0003_0005);
    stall_cnt = 0;
    repeat (20) begin
      if (out_stall) stall_cnt++;
      @(negedge clk);
    end
    check("basic_stall_cycles", stall_cnt, 32'd17);
    check("basic_data", out_data, 32'h0000_000F);
    run_word(32'h0003_0005, 32'h0000_000F, "basic");
    run_word(32'hFFFF_FFFF, 32'hFFFE_0001, "max");
    run_word(32'h0000_1234, 32'h0000_0000, "zero_a");
    run_word(32'h8000_0002, 32'h0001_0000, "msb");

    // Downstream stall with a competing operand offered.
    send(32'h0007_0009);
    in_stall = 1'b1;
    wait_valid(c);
    check("stall_latency", c, 32'd16);
    held = out_data;
    check("stall_data", held, 32'h0000_003F);
    in_data = 32'h000B_000D; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
      check("stall_hold_data", out_data, held);
      check("stall_hold_stall", {31'd0, out_stall}, 32'd1);
    end
    in_stall = 1'b0;
    @(negedge clk);
    check("release_valid_drop", {31'd0, out_valid}, 32'd0);
    check("release_idle", {31'd0, out_stall}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("release_accept", {31'd0, out_stall}, 32'd1);
    wait_valid(c);
    check("release_latency", c, 32'd16);
    check("release_data", out_data, 32'h0000_008F);
    @(negedge clk);

    // Flush in the middle of a BUSY phase.
    send(32'h0002_0003);
    repeat (6) @(negedge clk);
    in_flush = 1'b1;
    @(negedge clk); in_flush = 1'b0;
    check("flush_out_flush", {31'd0, out_flush}, 32'd1);
    check("flush_stall_drop", {31'd0, out_stall}, 32'd0);
    @(negedge clk);
    check("flush_pulse_end", {31'd0, out_flush}, 32'd0);
    quiet(20, "flush_no_valid");
    run_word(32'h0004_0004, 32'h0000_0010, "post_flush");

    // Flush together with a valid word in IDLE.
    @(negedge clk); in_data = 32'h0005_0005; in_valid = 1'b1; in_flush = 1'b1;
    @(negedge clk); in_valid = 1'b0; in_flush = 1'b0;
    check("flushv_stall", {31'd0, out_stall}, 32'd0);
    check("flushv_out_flush", {31'd0, out_flush}, 32'd1);
    quiet(20, "flushv_no_valid");

    // Reset during BUSY discards the operation immediately.
    send(32'h0003_0003);
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rstmid_stall", {31'd0, out_stall}, 32'd0);
    check("rstmid_valid", {31'd0, out_valid}, 32'd0);
    check("rstmid_data", out_data, 32'd0);
    check("rstmid_flush", {31'd0, out_flush}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    quiet(25, "rstmid_no_valid");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
